// File: rtl/dfe_satu_pkg.sv
// dfe_satu shared types and helpers.
// Window FSM states, clamp constants and overflow detection.
package dfe_satu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    EVAL = 2'd2
  } win_state_e;

  // Widths are limited to 63 bits so all helpers fit one 64-bit word.
  function automatic logic [63:0] sat_max(input int w);
    sat_max = (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    sat_min = 64'd1 << (w - 1);
  endfunction

  // Overflow when bits [din_w-1:dout_w-1] are not all equal.
  function automatic logic ovf_det(
    input logic [63:0] d,
    input int          din_w,
    input int          dout_w
  );
    logic [63:0] m;
    logic [63:0] t;
    m = ((64'd1 << din_w) - 64'd1) &
        ~((64'd1 << (dout_w - 1)) - 64'd1);
    t = d & m;
    ovf_det = (t != 64'd0) && (t != m);
  endfunction

endpackage

// File: rtl/dfe_satu_pipe.sv
// dfe_satu two-stage tagged saturating truncator.
// Stage 1 captures sample/ID and flags overflow, stage 2 clamps.
module dfe_satu_pipe #(
  parameter int DIN_WIDTH  = 39,
  parameter int DOUT_WIDTH = 17,
  parameter int CH_W       = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DIN_WIDTH-1:0]  i_data,
  input  logic [CH_W-1:0]       i_id,
  input  logic                  i_valid,
  output logic [DOUT_WIDTH-1:0] o_data,
  output logic [CH_W-1:0]       o_id,
  output logic                  o_valid,
  output logic                  o_ovf
);
  import dfe_satu_pkg::*;

  localparam logic [63:0] MAX64 = sat_max(DOUT_WIDTH);
  localparam logic [63:0] MIN64 = sat_min(DOUT_WIDTH);
  localparam logic [DOUT_WIDTH-1:0] MAXV =
    MAX64[DOUT_WIDTH-1:0];
  localparam logic [DOUT_WIDTH-1:0] MINV =
    MIN64[DOUT_WIDTH-1:0];

  logic [DIN_WIDTH-1:0]  s1_data;
  logic [CH_W-1:0]       s1_id;
  logic                  s1_valid;
  logic                  s1_ovf;
  logic                  in_ovf;
  logic [DOUT_WIDTH-1:0] sat_word;

  assign in_ovf = ovf_det(64'(i_data), DIN_WIDTH,
                          DOUT_WIDTH);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_id    <= '0;
      s1_ovf   <= 1'b0;
    end else begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_data <= i_data;
        s1_id   <= i_id;
        s1_ovf  <= in_ovf;
      end
    end
  end

  always_comb begin
    sat_word = s1_data[DOUT_WIDTH-1:0];
    unique case (1'b1)
      !s1_ovf:
        sat_word = s1_data[DOUT_WIDTH-1:0];
      s1_ovf && s1_data[DIN_WIDTH-1]:
        sat_word = MINV;
      s1_ovf && !s1_data[DIN_WIDTH-1]:
        sat_word = MAXV;
      default:
        sat_word = s1_data[DOUT_WIDTH-1:0];
    endcase
  end

  // Data and ID hold their last value between words.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_ovf   <= 1'b0;
      o_data  <= '0;
      o_id    <= '0;
    end else begin
      o_valid <= s1_valid;
      o_ovf   <= s1_valid & s1_ovf;
      if (s1_valid) begin
        o_data <= sat_word;
        o_id   <= s1_id;
      end
    end
  end

endmodule

// File: rtl/dfe_satu_sched.sv
// dfe_satu round-robin saturation scheduler with window statistics.
// Define DFE_SATU_SCHED_PRIO_EN to give ch0 strict priority.
module dfe_satu_sched #(
  parameter int NUM_CH     = 4,
  parameter int DIN_WIDTH  = 39,
  parameter int DOUT_WIDTH = 17,
  parameter int CNT_WIDTH  = 16,
  localparam int CH_W      = $clog2(NUM_CH)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_CH*DIN_WIDTH-1:0] i_ch_data,
  input  logic [NUM_CH-1:0]           i_ch_valid,
  output logic [NUM_CH-1:0]           o_ch_ready,
  output logic [DOUT_WIDTH-1:0]       o_data,
  output logic                        o_valid,
  output logic [CH_W-1:0]             o_ch_id,
  input  logic [CNT_WIDTH-1:0]        i_win_len,
  input  logic [CNT_WIDTH-1:0]        i_thresh,
  input  logic                        i_clr,
  output logic [NUM_CH-1:0]           o_sat_flag,
  output logic                        o_win_done
);
  import dfe_satu_pkg::*;

  logic [CH_W-1:0]      ptr_q;
  logic [NUM_CH-1:0]    rr_req;
  logic                 hi_req;
  logic                 rr_hit;
  logic [CH_W-1:0]      rr_id;
  logic [CH_W:0]        sum;
  logic [CH_W-1:0]      gnt_id;
  logic                 xfer;
  logic [DIN_WIDTH-1:0] sel_data;
  logic                 ev;
  logic [CH_W-1:0]      ev_id;

`ifdef DFE_SATU_SCHED_PRIO_EN
  assign hi_req = i_ch_valid[0];
  assign rr_req = {i_ch_valid[NUM_CH-1:1], 1'b0};
`else
  assign hi_req = 1'b0;
  assign rr_req = i_ch_valid;
`endif

  // Search from last grant + 1, wrapping modulo NUM_CH.
  always_comb begin
    rr_hit = 1'b0;
    rr_id  = '0;
    sum    = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      sum = {1'b0, ptr_q} + (CH_W+1)'(i);
      if (sum >= (CH_W+1)'(NUM_CH))
        sum = sum - (CH_W+1)'(NUM_CH);
      if (!rr_hit && rr_req[sum[CH_W-1:0]]) begin
        rr_hit = 1'b1;
        rr_id  = sum[CH_W-1:0];
      end
    end
  end

  assign xfer   = hi_req | rr_hit;
  assign gnt_id = hi_req ? '0 : rr_id;
  assign o_ch_ready =
    xfer ? (NUM_CH'(1) << gnt_id) : '0;

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (gnt_id == CH_W'(k))
        sel_data = i_ch_data[k*DIN_WIDTH +: DIN_WIDTH];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      ptr_q <= CH_W'(NUM_CH - 1);
    else if (rr_hit && !hi_req)
      ptr_q <= gnt_id;
  end

  dfe_satu_pipe #(
    .DIN_WIDTH  (DIN_WIDTH),
    .DOUT_WIDTH (DOUT_WIDTH),
    .CH_W       (CH_W)
  ) u_pipe (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_data  (sel_data),
    .i_id    (gnt_id),
    .i_valid (xfer),
    .o_data  (o_data),
    .o_id    (ev_id),
    .o_valid (o_valid),
    .o_ovf   (ev)
  );

  assign o_ch_id = ev_id;

  win_state_e           state_q;
  win_state_e           state_d;
  logic [CNT_WIDTH-1:0] win_cnt;
  logic [CNT_WIDTH-1:0] cnt     [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0]    hit;
  logic                 len_zero;
  logic                 eval;

  assign len_zero = (i_win_len == '0);
  assign eval = (state_q == EVAL) && !len_zero && !i_clr;
  assign o_win_done = eval;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (!len_zero) state_d = RUN;
      RUN: begin
        if (len_zero)
          state_d = IDLE;
        else if (win_cnt >= i_win_len - CNT_WIDTH'(1))
          state_d = EVAL;
      end
      EVAL: state_d = len_zero ? IDLE : RUN;
      default: state_d = IDLE;
    endcase
    if (i_clr)
      state_d = len_zero ? IDLE : RUN;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      win_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == RUN && !i_clr)
        win_cnt <= win_cnt + CNT_WIDTH'(1);
      else
        win_cnt <= '0;
    end
  end

  // Closing-window events are folded in before the compare.
  always_comb begin
    hit = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cnt_nxt[k] = cnt[k];
      if (ev && ev_id == CH_W'(k) && cnt[k] != '1)
        cnt_nxt[k] = cnt[k] + CNT_WIDTH'(1);
      hit[k] = (i_thresh != '0) &&
               (cnt_nxt[k] >= i_thresh);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_sat_flag <= '0;
      for (int k = 0; k < NUM_CH; k++)
        cnt[k] <= '0;
    end else begin
      if (i_clr)
        o_sat_flag <= '0;
      else if (eval)
        o_sat_flag <= o_sat_flag | hit;
      for (int k = 0; k < NUM_CH; k++) begin
        if (i_clr || eval)
          cnt[k] <= '0;
        else
          cnt[k] <= cnt_nxt[k];
      end
    end
  end

endmodule

// File: doc/dfe_satu_sched.md
Name: dfe_satu_sched

Overview:
- Time-multiplexed saturation scheduler for the DFE datapath.
- Round-robin arbitrates NUM_CH wide accumulator channels onto one shared saturating-truncation pipeline (DIN_WIDTH to DOUT_WIDTH).
- Tags each output word with its channel ID.
- Keeps per-channel saturation-event statistics over a programmable window; raises sticky alarm flags for the regmap/CPU.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8)
- DIN_WIDTH, 39, input sample width, two's complement
- DOUT_WIDTH, 17, output sample width, two's complement
- CNT_WIDTH, 16, width of window length, threshold and event counters
- CH_W, $clog2(NUM_CH), channel-ID width (derived localparam)

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset; asynchronous, active-high
- i_ch_data  in  NUM_CH*DIN_WIDTH  channel samples; ch k at [k*DIN_WIDTH +: DIN_WIDTH]
- i_ch_valid  in  NUM_CH  per-channel sample valid
- o_ch_ready  out  NUM_CH  one-hot grant; transfer when valid&ready
- o_data  out  DOUT_WIDTH  saturated/truncated sample
- o_valid  out  1  o_data/o_ch_id valid; no backpressure
- o_ch_id  out  CH_W  source channel of o_data
- i_win_len  in  CNT_WIDTH  statistics window in clocks; 0 = statistics disabled
- i_thresh  in  CNT_WIDTH  per-window event count that sets alarm; 0 = never alarm
- i_clr  in  1  sync clear of counters, flags and window
- o_sat_flag  out  NUM_CH  sticky per-channel alarm
- o_win_done  out  1  one-cycle pulse at each window evaluation

Behaviour:
- Reset: all outputs 0; RR pointer = NUM_CH-1, so ch0 is first in search order; FSM = IDLE; counters 0.
- Arbitration: combinational grant. Search starts at last granted channel + 1, wraps modulo NUM_CH, first asserted valid wins. o_ch_ready is 0 when no valid. Pointer updates only on transfer. At most one transfer per cycle.
- Pipeline: transfer in cycle N → o_valid=1 in cycle N+2.
  - Stage 1 registers sample and ID, and computes OVF = bits [DIN_WIDTH-1:DOUT_WIDTH-1] not all equal.
  - Stage 2 outputs:
    - !OVF → low DOUT_WIDTH bits.
    - OVF & sign=0 → 0 followed by all ones (0x0FFFF for 17b).
    - OVF & sign=1 → 1 followed by all zeros (0x10000).
  - o_data/o_ch_id hold last value when o_valid=0.
- Saturation event: stage-2 word with OVF=1 increments cnt[o_ch_id]. Counters saturate at all ones; no wrap.
- Window FSM:
  - IDLE: i_win_len==0. Window counter held at 0. Event counters still count, saturating. No evaluation.
  - RUN: window counter increments each clock. On reaching i_win_len-1, go to EVAL.
  - EVAL (one cycle): for each ch, if i_thresh!=0 and cnt>=i_thresh, set o_sat_flag[ch]. Pulse o_win_done. Clear cnt and window counter. Events in this same cycle are counted into the closing window before compare. Next state is RUN, or IDLE if i_win_len==0.
  - RUN/EVAL with i_win_len changed to 0: go to IDLE next cycle without evaluating.
  - i_win_len==1: RUN, EVAL alternate.
- i_clr: clears cnt, o_sat_flag and window counter; FSM goes to RUN (or IDLE). An event coinciding with i_clr is dropped; i_clr has priority over EVAL. The pipeline and RR pointer are unaffected.
- Reset mid-operation: in-flight pipeline words are discarded; o_valid goes low asynchronously.

Optional Feature:
- Macro DFE_SATU_SCHED_PRIO_EN.
- Defined: ch0 has strict priority; if i_ch_valid[0], grant ch0. Remaining channels use round-robin among themselves, and the pointer does not advance on ch0 grants.
- Undefined: pure round-robin over all channels.

Decomposition:
- Package dfe_satu_pkg: FSM state typedef (IDLE, RUN, EVAL), clamp-constant functions for max positive / min negative given DOUT_WIDTH, OVF-detect function.
- Sub-module dfe_satu_pipe: two-stage tagged saturator (data, ID, valid in; data, ID, valid, ovf out). Arbiter and statistics stay in the top level.

Test Plan:
- Single ch0, data 39'h00_0000_1234 → o_data=17'h01234, o_ch_id=0, o_valid exactly 2 cycles after transfer.
- ch1 data 39'h00_0001_0000 → 17'h0FFFF. ch2 data 39'h40_0000_0000 → 17'h10000. ch3 data 39'h7F_FFFF_FFFF → 17'h1FFFF, no event counted.
- All 4 valid continuously for 8 cycles → grants 0,1,2,3,0,1,2,3. Under DFE_SATU_SCHED_PRIO_EN with ch0 always valid → ch0 every cycle.
- i_win_len=10, i_thresh=3, ch1 overflows 3 times in window → o_win_done at cycle 10, o_sat_flag=4'b0010. Only 2 overflows → flag stays 0.
- Overflow in the EVAL cycle counts toward the closing window. i_clr coinciding with an overflow → counter stays 0, flags cleared.
- Assert i_rst while words are in flight → o_valid=0 immediately, no output after release until a new transfer; first grant goes to ch0.
